// File: rtl/burst_pkg.sv
// Shared definitions for the burst write path: sequencer FSM encoding,
// default interface widths and a bytes-per-burst helper.
package burst_pkg;

  // Defaults shared with burst_write_wf and its testbench.
  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_BURST_COUNT   = 8;
  localparam int DEFAULT_BURST_WIDTH   = 4;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_WAIT_DATA,
    ST_LAUNCH,
    ST_WAIT_ACK,
    ST_WAIT_END,
    ST_DONE
  } seq_state_t;

  // Number of bytes covered by a burst of 'words' data words.
  function automatic logic [31:0] burst_bytes(input logic [31:0] words,
                                              input int unsigned byte_log2);
    return words << byte_log2;
  endfunction

endpackage

// File: rtl/burst_seq_calc.sv
// Combinational burst sizing: bsize = min(rem, BURST_COUNT), plus the address
// and remaining-word count that follow once that burst has completed.
module burst_seq_calc
  import burst_pkg::*;
#(
  parameter int ADDRESS_WIDTH          = DEFAULT_ADDRESS_WIDTH,
  parameter int LENGTH_WIDTH           = 32,
  parameter int BYTE_ENABLE_WIDTH_LOG2 = 2,
  parameter int BURST_COUNT            = DEFAULT_BURST_COUNT,
  parameter int BURST_WIDTH            = DEFAULT_BURST_WIDTH
) (
  input  logic [LENGTH_WIDTH-1:0]  i_rem,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  output logic [BURST_WIDTH-1:0]   o_bsize,
  output logic [ADDRESS_WIDTH-1:0] o_next_addr,
  output logic [LENGTH_WIDTH-1:0]  o_next_rem,
  output logic                     o_rem_zero
);

  // Clamp the remaining count to one burst and derive the post-burst pointers.
  always_comb begin
    o_rem_zero = (i_rem == '0);
    // When rem is below BURST_COUNT it fits in BURST_WIDTH bits, so the
    // truncating cast loses nothing.
    if (i_rem >= LENGTH_WIDTH'(BURST_COUNT)) begin
      o_bsize = BURST_WIDTH'(BURST_COUNT);
    end else begin
      o_bsize = BURST_WIDTH'(i_rem);
    end
    // Address wraps modulo 2^ADDRESS_WIDTH; no page-boundary handling.
    o_next_addr = i_addr + ADDRESS_WIDTH'(burst_bytes(32'(o_bsize), BYTE_ENABLE_WIDTH_LOG2));
    // bsize <= rem by construction, so this never underflows.
    o_next_rem  = i_rem - LENGTH_WIDTH'(o_bsize);
  end

endmodule

// File: rtl/burst_write_seq.sv
// Command sequencer in front of burst_write_wf: splits one (address, length)
// command into bursts of at most BURST_COUNT words, launching each only once
// the upstream FIFO holds the whole burst.
module burst_write_seq
  import burst_pkg::*;
#(
  parameter int ADDRESS_WIDTH          = DEFAULT_ADDRESS_WIDTH,
  parameter int LENGTH_WIDTH           = 32,  // must be <= ADDRESS_WIDTH
  parameter int BYTE_ENABLE_WIDTH_LOG2 = 2,
  parameter int BURST_COUNT            = DEFAULT_BURST_COUNT,
  parameter int BURST_WIDTH            = DEFAULT_BURST_WIDTH,
  parameter int LEVEL_WIDTH            = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_start,
  input  logic [ADDRESS_WIDTH-1:0] cmd_baseaddress,
  input  logic [LENGTH_WIDTH-1:0]  cmd_length,
  output logic                     cmd_busy,
  output logic                     cmd_done,
  input  logic [LEVEL_WIDTH-1:0]   src_level,
  output logic                     wr_ctrl_start,
  output logic [ADDRESS_WIDTH-1:0] wr_ctrl_baseaddress,
  output logic [BURST_WIDTH-1:0]   wr_ctrl_burstcount,
  input  logic                     wr_ctrl_busy
);

  // Common width for the unsigned FIFO-level versus burst-size compare.
  localparam int CMP_W = (LEVEL_WIDTH > BURST_WIDTH) ? LEVEL_WIDTH : BURST_WIDTH;

  seq_state_t r_state;
  seq_state_t w_next_state;

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [LENGTH_WIDTH-1:0]  r_rem;
  logic [BURST_WIDTH-1:0]   r_bsize;
  logic                     r_ack_seen;

  logic [BURST_WIDTH-1:0]   w_bsize;
  logic [ADDRESS_WIDTH-1:0] w_next_addr;
  logic [LENGTH_WIDTH-1:0]  w_next_rem;
  logic                     w_rem_zero;
  logic                     w_level_ok;

  burst_seq_calc #(
    .ADDRESS_WIDTH          (ADDRESS_WIDTH),
    .LENGTH_WIDTH           (LENGTH_WIDTH),
    .BYTE_ENABLE_WIDTH_LOG2 (BYTE_ENABLE_WIDTH_LOG2),
    .BURST_COUNT            (BURST_COUNT),
    .BURST_WIDTH            (BURST_WIDTH)
  ) u_calc (
    .i_rem       (r_rem),
    .i_addr      (r_addr),
    .o_bsize     (w_bsize),
    .o_next_addr (w_next_addr),
    .o_next_rem  (w_next_rem),
    .o_rem_zero  (w_rem_zero)
  );

  assign w_level_ok = CMP_W'(src_level) >= CMP_W'(r_bsize);

  // The burst target is presented straight from the working registers, which
  // only change on command accept or after busy falls, so they stay stable
  // across the whole burst.
  assign wr_ctrl_baseaddress = r_addr;
  assign wr_ctrl_burstcount  = r_bsize;

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and Moore output decode.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state  = r_state;
    cmd_busy      = 1'b0;
    cmd_done      = 1'b0;
    wr_ctrl_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_start) w_next_state = ST_CALC;
      end
      ST_CALC: begin
        cmd_busy     = 1'b1;
        w_next_state = w_rem_zero ? ST_DONE : ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        cmd_busy = 1'b1;
        if (w_level_ok) w_next_state = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        cmd_busy      = 1'b1;
        wr_ctrl_start = 1'b1;
        w_next_state  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        cmd_busy = 1'b1;
        // A writer that raised busy already during LAUNCH may drop it again
        // before we get here; the captured flag covers that case.
        if (wr_ctrl_busy || r_ack_seen) w_next_state = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        cmd_busy = 1'b1;
        if (!wr_ctrl_busy) w_next_state = ST_CALC;
      end
      ST_DONE: begin
        cmd_done     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Working registers: command latch, burst size capture, early-ack capture
  // and the post-burst address/remaining update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_rem      <= '0;
      r_bsize    <= '0;
      r_ack_seen <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_start) begin
            r_addr <= cmd_baseaddress;
            r_rem  <= cmd_length;
          end
        end
        ST_CALC: begin
          r_bsize <= w_bsize;
        end
        ST_LAUNCH: begin
          r_ack_seen <= wr_ctrl_busy;
        end
        ST_WAIT_END: begin
          // rem is unchanged since CALC, so the calculator still reflects the
          // burst that just finished.
          if (!wr_ctrl_busy) begin
            r_addr <= w_next_addr;
            r_rem  <= w_next_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_write_seq.sv
// Self-checking bench for burst_write_seq: a behavioural burst_write_wf
// responder, a list-based reference model of the expected burst sequence and
// one task per scenario.
module tb_burst_write_seq;

  localparam int AW  = 32;
  localparam int LW  = 32;
  localparam int BW  = 4;
  localparam int LVW = 10;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  cnt;
  } burst_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cmd_start;
  logic [AW-1:0]   cmd_baseaddress;
  logic [LW-1:0]   cmd_length;
  logic            cmd_busy;
  logic            cmd_done;
  logic [LVW-1:0]  src_level;
  logic            wr_ctrl_start;
  logic [AW-1:0]   wr_ctrl_baseaddress;
  logic [BW-1:0]   wr_ctrl_burstcount;
  logic            wr_ctrl_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Level source: fixed value or per-cycle random value.
  logic [LVW-1:0] fixed_level = 10'd64;
  logic [LVW-1:0] rnd_level   = '0;
  bit             rand_level  = 1'b0;
  assign src_level = rand_level ? rnd_level : fixed_level;

  // Responder controls.
  bit rand_resp      = 1'b0;
  int fixed_busy_len = 10;
  int fixed_ack_dly  = 1;

  // Monitor/responder state.
  burst_t launches[$];
  burst_t exp_q[$];
  int     done_cnt   = 0;
  int     proto_err  = 0;
  int     level_err  = 0;
  int     hold       = 0;
  int     ack_wait   = 0;
  int     cur_len    = 0;
  bit     last_start = 1'b0;

  always #5 clk = ~clk;

  burst_write_seq dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cmd_start           (cmd_start),
    .cmd_baseaddress     (cmd_baseaddress),
    .cmd_length          (cmd_length),
    .cmd_busy            (cmd_busy),
    .cmd_done            (cmd_done),
    .src_level           (src_level),
    .wr_ctrl_start       (wr_ctrl_start),
    .wr_ctrl_baseaddress (wr_ctrl_baseaddress),
    .wr_ctrl_burstcount  (wr_ctrl_burstcount),
    .wr_ctrl_busy        (wr_ctrl_busy)
  );

  // Behavioural burst_write_wf: records launches, raises busy after a
  // programmable delay (0 = already during the launch cycle), holds it, drops it.
  always @(negedge clk) begin
    if (!reset_n) begin
      wr_ctrl_busy = 1'b0;
      hold         = 0;
      ack_wait     = 0;
      last_start   = 1'b0;
    end else begin
      int dly;
      bit st;
      st = wr_ctrl_start;
      if (cmd_done) done_cnt++;
      if (st) begin
        launches.push_back('{addr: wr_ctrl_baseaddress, cnt: wr_ctrl_burstcount});
        if (wr_ctrl_busy || hold > 0 || ack_wait > 0 || last_start) proto_err++;
        if (src_level < 10'(wr_ctrl_burstcount)) level_err++;
      end
      last_start = st;
      if (hold > 0) begin
        hold--;
        if (hold == 0) wr_ctrl_busy = 1'b0;
      end else if (ack_wait > 0) begin
        ack_wait--;
        if (ack_wait == 0) begin
          wr_ctrl_busy = 1'b1;
          hold = cur_len;
        end
      end
      if (st) begin
        cur_len = rand_resp ? $urandom_range(1, 6) : fixed_busy_len;
        dly     = rand_resp ? $urandom_range(0, 2) : fixed_ack_dly;
        if (dly == 0) begin
          wr_ctrl_busy = 1'b1;
          hold = cur_len;
        end else begin
          ack_wait = dly;
        end
      end
      if (rand_level) rnd_level = 10'($urandom_range(0, 15));
    end
  end

  // Reference model: the command is cut into min(remaining, 8)-word bursts,
  // each 4 bytes per word further on, address wrapping at 32 bits.
  function automatic void build_expected(input logic [31:0] base, input logic [31:0] len);
    logic [31:0] a;
    longint      r;
    longint      b;
    exp_q.delete();
    a = base;
    r = longint'(len);
    while (r > 0) begin
      b = (r > 8) ? 8 : r;
      exp_q.push_back('{addr: a, cnt: 4'(b)});
      a = a + 32'(b * 4);
      r = r - b;
    end
  endfunction

  // Issue one command, optionally spamming cmd_start while busy, and score the
  // resulting burst sequence against the model.
  task automatic run_cmd(input string name, input logic [31:0] base,
                         input logic [31:0] len, input bit spam);
    int lb, db, pb, eb, cycles, gap, n;
    bit got_done, done_busy;
    lb = launches.size(); db = done_cnt; pb = proto_err; eb = level_err;
    cycles = 0; gap = 0; got_done = 1'b0; done_busy = 1'b0;
    build_expected(base, len);
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_baseaddress = base; cmd_length = len;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    while (!got_done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (cmd_done) begin
        got_done  = 1'b1;
        done_busy = cmd_busy;
      end else if (!cmd_busy) begin
        gap++;
      end
      if (spam && !got_done && cmd_busy && !cmd_start && $urandom_range(0, 2) == 0) begin
        cmd_start = 1'b1;
        cmd_baseaddress = $urandom;
        cmd_length = $urandom_range(1, 50);
      end else begin
        cmd_start = 1'b0;
      end
    end
    cmd_start = 1'b0;
    n_checks++;
    if (got_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done_timeout: no cmd_done within %0d cycles", name, cycles);
      reset_n = 1'b0; #3; reset_n = 1'b1;
    end
    @(negedge clk);
    n_checks++;
    if (gap !== 0) begin
      n_fail++; $display("FAIL %s_busy_gap: cmd_busy low %0d cycles before done, expected 0", name, gap);
    end
    n_checks++;
    if (done_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy_at_done: got %0b expected 0", name, done_busy);
    end
    n_checks++;
    if (cmd_done !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_width: cmd_done still %0b after pulse, expected 0", name, cmd_done);
    end
    n_checks++;
    if (done_cnt - db !== 1) begin
      n_fail++; $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt - db);
    end
    n_checks++;
    if (launches.size() - lb !== exp_q.size()) begin
      n_fail++; $display("FAIL %s_burst_count: got %0d bursts expected %0d", name, launches.size() - lb, exp_q.size());
    end
    n = launches.size() - lb;
    if (exp_q.size() < n) n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (launches[lb + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_burst%0d: got addr=%08h cnt=%0d expected addr=%08h cnt=%0d", name, i,
                 launches[lb + i].addr, launches[lb + i].cnt, exp_q[i].addr, exp_q[i].cnt);
      end
    end
    n_checks++;
    if (proto_err - pb !== 0 || level_err - eb !== 0) begin
      n_fail++; $display("FAIL %s_protocol: got %0d launch and %0d level violations expected 0", name,
                         proto_err - pb, level_err - eb);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_start = 1'b0; cmd_baseaddress = '0; cmd_length = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_busy, cmd_done, wr_ctrl_start} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %03b expected 000", {cmd_busy, cmd_done, wr_ctrl_start});
    end
    n_checks++;
    if (wr_ctrl_baseaddress !== 32'h0 || wr_ctrl_burstcount !== 4'h0) begin
      n_fail++; $display("FAIL reset_target: got %08h/%0d expected 0/0", wr_ctrl_baseaddress, wr_ctrl_burstcount);
    end
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cmd_busy, cmd_done, wr_ctrl_start} !== 3'b000) begin
      n_fail++; $display("FAIL idle_flags: got %03b expected 000", {cmd_busy, cmd_done, wr_ctrl_start});
    end
  endtask

  task automatic test_main_bursts();
    fixed_level = 10'd64; fixed_busy_len = 10; fixed_ack_dly = 1;
    run_cmd("len32", 32'h3800_0000, 32'd32, 1'b0);
    run_cmd("len13", 32'h3800_0000, 32'd13, 1'b0);
    fixed_ack_dly = 0; fixed_busy_len = 1;
    run_cmd("early_ack", 32'h0000_1000, 32'd17, 1'b0);
    fixed_ack_dly = 2; fixed_busy_len = 3;
    run_cmd("wrap", 32'hFFFF_FFE8, 32'd13, 1'b0);
  endtask

  task automatic test_zero_length();
    int lb, db;
    lb = launches.size(); db = done_cnt;
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_baseaddress = 32'h0000_4000; cmd_length = '0;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cmd_busy, cmd_done} !== 2'b10) begin
      n_fail++; $display("FAIL zero_cycle1: busy/done got %02b expected 10", {cmd_busy, cmd_done});
    end
    @(negedge clk);
    n_checks++;
    if ({cmd_busy, cmd_done} !== 2'b01) begin
      n_fail++; $display("FAIL zero_cycle2: busy/done got %02b expected 01", {cmd_busy, cmd_done});
    end
    @(negedge clk);
    n_checks++;
    if ({cmd_busy, cmd_done} !== 2'b00) begin
      n_fail++; $display("FAIL zero_cycle3: busy/done got %02b expected 00", {cmd_busy, cmd_done});
    end
    n_checks++;
    if (launches.size() - lb !== 0 || done_cnt - db !== 1) begin
      n_fail++; $display("FAIL zero_launch: got %0d launches %0d dones expected 0 and 1",
                         launches.size() - lb, done_cnt - db);
    end
  endtask

  task automatic test_level_gate();
    int lb, db, cycles;
    lb = launches.size(); db = done_cnt;
    fixed_level = 10'd5; fixed_busy_len = 4; fixed_ack_dly = 1;
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_baseaddress = 32'h0000_8000; cmd_length = 32'd8;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (launches.size() - lb !== 0 || cmd_busy !== 1'b1) begin
      n_fail++; $display("FAIL gate_hold: got %0d launches busy=%0b expected 0 launches busy=1",
                         launches.size() - lb, cmd_busy);
    end
    @(posedge clk); #1;
    fixed_level = 10'd8;
    @(negedge clk);
    n_checks++;
    if (wr_ctrl_start !== 1'b0) begin
      n_fail++; $display("FAIL gate_early: wr_ctrl_start got %0b expected 0", wr_ctrl_start);
    end
    @(negedge clk);
    n_checks++;
    if (wr_ctrl_start !== 1'b1 || wr_ctrl_baseaddress !== 32'h0000_8000 || wr_ctrl_burstcount !== 4'd8) begin
      n_fail++; $display("FAIL gate_launch: got start=%0b addr=%08h cnt=%0d expected 1/00008000/8",
                         wr_ctrl_start, wr_ctrl_baseaddress, wr_ctrl_burstcount);
    end
    cycles = 0;
    while (done_cnt == db && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    @(negedge clk);
    n_checks++;
    if (done_cnt - db !== 1) begin
      n_fail++; $display("FAIL gate_done: got %0d dones expected 1", done_cnt - db);
    end
    fixed_level = 10'd64;
  endtask

  task automatic test_ignore_start();
    fixed_level = 10'd64; fixed_busy_len = 5; fixed_ack_dly = 1;
    run_cmd("ignore_start", 32'h0100_0000, 32'd29, 1'b1);
  endtask

  task automatic test_reset_mid();
    int lb, db, cycles;
    lb = launches.size(); db = done_cnt;
    fixed_busy_len = 10; fixed_ack_dly = 1;
    @(posedge clk); #1;
    cmd_start = 1'b1; cmd_baseaddress = 32'h1000_0000; cmd_length = 32'd16;
    @(posedge clk); #1;
    cmd_start = 1'b0;
    cycles = 0;
    while (launches.size() == lb && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_busy, cmd_done, wr_ctrl_start} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_flags: got %03b expected 000", {cmd_busy, cmd_done, wr_ctrl_start});
    end
    n_checks++;
    if (wr_ctrl_baseaddress !== 32'h0 || wr_ctrl_burstcount !== 4'h0) begin
      n_fail++; $display("FAIL midreset_target: got %08h/%0d expected 0/0", wr_ctrl_baseaddress, wr_ctrl_burstcount);
    end
    @(negedge clk); #2 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (done_cnt - db !== 0 || cmd_busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_nodone: got %0d dones busy=%0b expected 0 and 0", done_cnt - db, cmd_busy);
    end
    run_cmd("after_reset", 32'h2000_0040, 32'd20, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] base;
    rand_level = 1'b1; rand_resp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      base = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      run_cmd($sformatf("rand%0d", i), base, 32'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
    end
    rand_level = 1'b0; rand_resp = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_main_bursts();
    test_zero_length();
    test_level_gate();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_write_seq.md
Name: burst_write_seq

Overview:
Command sequencer that sits directly upstream of the burst_write_wf Avalon-MM burst write master.
- Accepts one transfer command: a base byte address and a length in words.
- Splits the transfer into bursts of at most BURST_COUNT words and issues each burst to burst_write_wf through its ctrl_start / ctrl_baseaddress / ctrl_burstcount / ctrl_busy interface.
- Launches a burst only when the upstream data FIFO holds enough words for the whole burst.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- LENGTH_WIDTH, 32, width of word-length fields; must be <= ADDRESS_WIDTH.
- BYTE_ENABLE_WIDTH_LOG2, 2, log2 of bytes per data word; sets the address step per word.
- BURST_COUNT, 8, maximum words per burst; power of 2, 1..1024.
- BURST_WIDTH, 4, width of burstcount; must satisfy 2^(BURST_WIDTH-1) >= BURST_COUNT.
- LEVEL_WIDTH, 10, width of the upstream FIFO fill-level input.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- cmd_start, in, 1, one-cycle command strobe; sampled only in IDLE.
- cmd_baseaddress, in, ADDRESS_WIDTH, byte address of the first word; word aligned.
- cmd_length, in, LENGTH_WIDTH, number of words to transfer.
- cmd_busy, out, 1, high from the cycle after an accepted cmd_start until cmd_done.
- cmd_done, out, 1, one-cycle pulse when the last burst has completed.
- src_level, in, LEVEL_WIDTH, words currently held in the upstream write-data FIFO.
- wr_ctrl_start, out, 1, one-cycle launch pulse to burst_write_wf ctrl_start.
- wr_ctrl_baseaddress, out, ADDRESS_WIDTH, to ctrl_baseaddress; held stable from the pulse until busy falls.
- wr_ctrl_burstcount, out, BURST_WIDTH, to ctrl_burstcount; held stable like the address.
- wr_ctrl_busy, in, 1, from burst_write_wf ctrl_busy.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal address and remaining-count registers 0.
- Reset mid-operation returns to IDLE immediately. No cmd_done is generated. Any burst already handed to burst_write_wf is abandoned.
- States: IDLE, CALC, WAIT_DATA, LAUNCH, WAIT_ACK, WAIT_END, DONE.
- IDLE: when cmd_start=1, latch addr=cmd_baseaddress and rem=cmd_length, assert cmd_busy, then go to CALC.
- CALC: compute bsize = min(rem, BURST_COUNT).
  - If rem==0, go to DONE; a zero-length command produces no wr_ctrl_start.
  - Otherwise go to WAIT_DATA.
- WAIT_DATA: stay until src_level >= bsize, then go to LAUNCH.
- LAUNCH: assert wr_ctrl_start for exactly 1 cycle with wr_ctrl_baseaddress=addr and wr_ctrl_burstcount=bsize, then go to WAIT_ACK.
- WAIT_ACK: wait for wr_ctrl_busy=1.
  - If wr_ctrl_busy was already 1 during the LAUNCH cycle, treat the burst as acknowledged.
  - Then go to WAIT_END.
- WAIT_END: on wr_ctrl_busy=0, update addr += bsize << BYTE_ENABLE_WIDTH_LOG2 and rem -= bsize, then go to CALC.
- DONE: pulse cmd_done for 1 cycle and deassert cmd_busy in the same cycle, then go to IDLE. A new cmd_start is accepted the following cycle.
- Timing: consecutive bursts are spaced by at least 3 cycles after busy falls (WAIT_END -> CALC -> WAIT_DATA -> LAUNCH). Minimum latency from cmd_start to the first wr_ctrl_start is 3 cycles.
- cmd_start is ignored in any state other than IDLE.
- Address arithmetic wraps modulo 2^ADDRESS_WIDTH with no error flag. No 4 KB boundary splitting.
- src_level is compared unsigned. If bsize exceeds 2^LEVEL_WIDTH-1, the block waits indefinitely; this is an integration error.
- Width rule: bsize is held in BURST_WIDTH bits. rem is held in LENGTH_WIDTH bits and never underflows.

Decomposition:
- Shared package burst_pkg holds:
  - the FSM state encoding;
  - the default ADDRESS_WIDTH, BURST_COUNT and BURST_WIDTH constants, reused by burst_write_wf and its testbench;
  - a function for bytes per burst.
- One sub-module is natural: burst_seq_calc, a combinational min(rem, BURST_COUNT) plus next-address/next-remaining calculator. Everything else stays in the top level.

Test Plan:
- cmd_length=32, cmd_baseaddress=0x38000000, src_level=64, responder busy for 10 cycles -> 4 bursts at 0x38000000, 0x38000020, 0x38000040, 0x38000060, each burstcount 8; exactly one cmd_done after the 4th busy fall.
- cmd_length=13 -> bursts of 8 at base and 5 at base+0x20; cmd_busy high throughout; cmd_done once.
- cmd_length=0 -> no wr_ctrl_start; cmd_done pulses 2 cycles after cmd_start (via CALC to DONE); cmd_busy high for exactly those cycles.
- src_level held at 5 with cmd_length=8 -> block stays in WAIT_DATA with no launch; raise src_level to 8 -> wr_ctrl_start 1 cycle later.
- cmd_start pulsed again while busy -> ignored; burst sequence and addresses unchanged.
- reset_n asserted during WAIT_END -> all outputs 0 asynchronously; no cmd_done; a fresh command after release runs correctly from its own base address.
